// File: rtl/p2s_rr_arbiter.sv
// p2s_rr_arbiter: round-robin arbiter sharing one parallel-to-serial serializer
// between M valid/ready requesters. A granted word is captured into a holding
// register and presented on p_valid/p_data until the serializer takes it. A
// grant may keep the serializer for up to BURST words if the owner stays valid.
module p2s_rr_arbiter #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int BURST = 1,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [M-1:0]         req_valid,
  input  logic [M*N-1:0]       req_data,
  output logic [M-1:0]         req_ready,
  output logic                 p_valid,
  output logic [N-1:0]         p_data,
  input  logic                 p_ready,
  output logic [$clog2(M)-1:0] grant_id,
  output logic                 busy,
  output logic [CW-1:0]        xfer_count
);

  localparam int IW = $clog2(M);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(M - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [BW-1:0] burst_cnt;
  logic [N-1:0]  data_reg;

  logic          any_valid;
  logic [IW-1:0] winner;
  logic          xfer;
  logic          extend;

  // Rotating-priority search: first valid requester starting at ptr, wrapping at M
  always_comb begin
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    winner    = '0;
    for (int k = 0; k < M; k++) begin
      idx = int'(ptr) + k;
      if (idx >= M) idx = idx - M;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = IW'(idx);
      end
    end
  end

  // A transfer in HOLD either continues the burst from the same owner or ends the grant
  always_comb begin
    xfer   = (state == HOLD) && p_ready;
    extend = xfer && (burst_cnt < BURST_MAX) && req_valid[grant_id];
  end

  // Take a word from at most one requester; forced low while reset is asserted
  always_comb begin
    req_ready = '0;
    if (rstn) begin
      if (state == IDLE && any_valid) begin
        req_ready[winner] = 1'b1;
      end else if (extend) begin
        req_ready[grant_id] = 1'b1;
      end
    end
  end

  // Serializer-facing outputs decode straight from registered state so they drop with rstn
  always_comb begin
    p_valid = (state == HOLD);
    busy    = (state == HOLD);
    p_data  = data_reg;
  end

  // Grant/hold state machine with holding register, rotation pointer and transfer counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      ptr        <= '0;
      burst_cnt  <= '0;
      data_reg   <= '0;
      grant_id   <= '0;
      xfer_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            data_reg  <= req_data[winner*N +: N];
            grant_id  <= winner;
            burst_cnt <= BURST_ONE;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (xfer) begin
            xfer_count <= xfer_count + 1'b1;
            if (extend) begin
              data_reg  <= req_data[grant_id*N +: N];
              burst_cnt <= burst_cnt + 1'b1;
            end else begin
              state     <= IDLE;
              ptr       <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
              burst_cnt <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Grants are exclusive and only ever go to a requester that is offering a word
  always @(posedge clk) begin
    if (rstn) begin
      assert ($onehot0(req_ready));
      assert ((req_ready & ~req_valid) == '0);
    end
  end

endmodule

// File: tb/tb_p2s_rr_arbiter.sv
// tb_p2s_rr_arbiter: three arbiter instances (M=4/BURST=1, M=4/BURST=2,
// M=3/BURST=1) checked every cycle against a behavioural model of the
// arbitration rules, plus directed checks with hand-computed values.
module tb_p2s_rr_arbiter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  logic [2:0][3:0]  rv;
  logic [2:0][31:0] rd;
  logic [2:0]       pr;

  logic [3:0]  rr0, rr1;
  logic [2:0]  rr2;
  logic        pv0, pv1, pv2, bz0, bz1, bz2;
  logic [7:0]  pd0, pd1, pd2;
  logic [1:0]  gid0, gid1, gid2;
  logic [15:0] xc0, xc1, xc2;

  logic [2:0][3:0]  rr;
  logic [2:0]       pv, bz;
  logic [2:0][7:0]  pd;
  logic [2:0][1:0]  gid;
  logic [2:0][15:0] xc;

  assign rr  = {{1'b0, rr2}, rr1, rr0};
  assign pv  = {pv2, pv1, pv0};
  assign bz  = {bz2, bz1, bz0};
  assign pd  = {pd2, pd1, pd0};
  assign gid = {gid2, gid1, gid0};
  assign xc  = {xc2, xc1, xc0};

  int testsRun    = 0;
  int testsFailed = 0;

  // model state per instance
  int        mM[3] = '{4, 4, 3};
  int        mB[3] = '{1, 2, 1};
  bit        mHold[3];
  int        mPtr[3];
  int        mGid[3];
  int        mCnt[3];
  int        mXfer[3];
  logic [7:0] mData[3];
  int        mLog[3][$];
  int        rdyCount[3][4];

  p2s_rr_arbiter #(.N(8), .M(4), .BURST(1), .CW(16)) dut0 (
    .clk(clk), .rstn(rstn), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr0),
    .p_valid(pv0), .p_data(pd0), .p_ready(pr[0]), .grant_id(gid0), .busy(bz0),
    .xfer_count(xc0));

  p2s_rr_arbiter #(.N(8), .M(4), .BURST(2), .CW(16)) dut1 (
    .clk(clk), .rstn(rstn), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr1),
    .p_valid(pv1), .p_data(pd1), .p_ready(pr[1]), .grant_id(gid1), .busy(bz1),
    .xfer_count(xc1));

  p2s_rr_arbiter #(.N(8), .M(3), .BURST(1), .CW(16)) dut2 (
    .clk(clk), .rstn(rstn), .req_valid(rv[2][2:0]), .req_data(rd[2][23:0]), .req_ready(rr2),
    .p_valid(pv2), .p_data(pd2), .p_ready(pr[2]), .grant_id(gid2), .busy(bz2),
    .xfer_count(xc2));

  // free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [3:0] v, input logic [31:0] d, input logic r);
    rv[i] = v;
    rd[i] = d;
    pr[i] = r;
  endtask

  task automatic doReset();
    rv   = '0;
    rd   = '0;
    pr   = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  function automatic void modelReset(input int i);
    mHold[i] = 1'b0;
    mPtr[i]  = 0;
    mGid[i]  = 0;
    mCnt[i]  = 0;
    mXfer[i] = 0;
    mData[i] = 8'h00;
  endfunction

  // first valid requester scanning ptr, ptr+1, ... modulo M; -1 when none
  function automatic int winnerOf(input int i);
    int idx;
    for (int k = 0; k < mM[i]; k++) begin
      idx = (mPtr[i] + k) % mM[i];
      if (rv[i][idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] expReady(input int i);
    logic [3:0] r;
    int w;
    r = 4'b0000;
    if (!rstn) return r;
    if (!mHold[i]) begin
      w = winnerOf(i);
      if (w >= 0) r[w] = 1'b1;
    end else if (pr[i] && mCnt[i] < mB[i] && rv[i][mGid[i]]) begin
      r[mGid[i]] = 1'b1;
    end
    return r;
  endfunction

  function automatic void stepModel(input int i);
    int w;
    if (!mHold[i]) begin
      w = winnerOf(i);
      if (w >= 0) begin
        mHold[i] = 1'b1;
        mData[i] = rd[i][w*8 +: 8];
        mGid[i]  = w;
        mCnt[i]  = 1;
      end
    end else if (pr[i]) begin
      mXfer[i] = (mXfer[i] + 1) % 65536;
      if (mCnt[i] < mB[i] && rv[i][mGid[i]]) begin
        mData[i] = rd[i][mGid[i]*8 +: 8];
        mCnt[i]  = mCnt[i] + 1;
      end else begin
        mHold[i] = 1'b0;
        mPtr[i]  = (mGid[i] + 1) % mM[i];
        mCnt[i]  = 0;
      end
    end
  endfunction

  // per-cycle comparison of every instance against the model, then advance the model
  always @(negedge clk) begin
    logic [3:0] er;
    for (int i = 0; i < 3; i++) begin
      if (!rstn) modelReset(i);
      er = expReady(i);
      checkOutput($sformatf("req_ready[inst%0d]", i), 32'(rr[i]), 32'(er));
      checkOutput($sformatf("p_valid[inst%0d]", i), 32'(pv[i]), 32'(mHold[i]));
      checkOutput($sformatf("busy[inst%0d]", i), 32'(bz[i]), 32'(mHold[i]));
      checkOutput($sformatf("p_data[inst%0d]", i), 32'(pd[i]), 32'(mData[i]));
      checkOutput($sformatf("grant_id[inst%0d]", i), 32'(gid[i]), 32'(mGid[i]));
      checkOutput($sformatf("xfer_count[inst%0d]", i), 32'(xc[i]), 32'(mXfer[i]));
      for (int j = 0; j < 4; j++) begin
        if (rr[i][j]) rdyCount[i][j]++;
        if (er[j]) mLog[i].push_back(j);
      end
      if (rstn) stepModel(i);
    end
  end

  // directed sequence
  initial begin
    int lb;
    int cnt0[4];
    int fairExp[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int burstExp[6] = '{0, 0, 1, 1, 0, 0};
    int wrapExp[4]  = '{0, 2, 0, 2};

    rv = '0;
    rd = '0;
    pr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_p_valid", 32'(pv0), 32'h0);
    checkOutput("reset_busy", 32'(bz0), 32'h0);
    checkOutput("reset_xfer_count", 32'(xc0), 32'h0);
    checkOutput("reset_grant_id", 32'(gid0), 32'h0);
    checkOutput("reset_p_data", 32'(pd0), 32'h0);
    rstn = 1'b1;

    // single requester 2 with 0xA5
    applyStimulus(0, 4'b0100, 32'h00A50000, 1'b1);
    #1;
    checkOutput("single_req_ready", 32'(rr0), 32'h4);
    @(posedge clk); #1;
    checkOutput("single_p_valid", 32'(pv0), 32'h1);
    checkOutput("single_p_data", 32'(pd0), 32'hA5);
    checkOutput("single_grant_id", 32'(gid0), 32'h2);
    applyStimulus(0, 4'b0000, 32'h0, 1'b1);
    @(posedge clk); #1;
    checkOutput("single_back_idle", 32'(pv0), 32'h0);
    checkOutput("single_xfer_count", 32'(xc0), 32'h1);
    checkOutput("single_model_ptr", 32'(mPtr[0]), 32'h3);
    applyStimulus(0, 4'b0000, 32'h0, 1'b0);

    // fairness: all four valid continuously
    doReset();
    lb = mLog[0].size();
    for (int j = 0; j < 4; j++) cnt0[j] = rdyCount[0][j];
    applyStimulus(0, 4'b1111, 32'h44332211, 1'b1);
    repeat (16) @(posedge clk);
    #1;
    applyStimulus(0, 4'b0000, 32'h0, 1'b0);
    checkOutput("fair_xfer_count", 32'(xc0), 32'h8);
    for (int j = 0; j < 4; j++)
      checkOutput($sformatf("fair_ready_count%0d", j), 32'(rdyCount[0][j] - cnt0[j]), 32'h2);
    checkOutput("fair_log_len", 32'(mLog[0].size() - lb), 32'h8);
    if (mLog[0].size() - lb >= 8)
      for (int k = 0; k < 8; k++)
        checkOutput($sformatf("fair_grant%0d", k), 32'(mLog[0][lb+k]), 32'(fairExp[k]));

    // burst of two, requesters 0 and 1 always valid
    lb = mLog[1].size();
    applyStimulus(1, 4'b0011, 32'h0000B2B1, 1'b1);
    #1;
    checkOutput("burst_first_ready", 32'(rr1), 32'h1);
    @(posedge clk); #1;
    checkOutput("burst_reload_ready", 32'(rr1), 32'h1);
    checkOutput("burst_reload_p_valid", 32'(pv1), 32'h1);
    @(posedge clk); #1;
    checkOutput("burst_second_p_valid", 32'(pv1), 32'h1);
    checkOutput("burst_second_ready", 32'(rr1), 32'h0);
    repeat (7) @(posedge clk);
    #1;
    applyStimulus(1, 4'b0000, 32'h0, 1'b0);
    checkOutput("burst_xfer_count", 32'(xc1), 32'h6);
    checkOutput("burst_log_len", 32'(mLog[1].size() - lb), 32'h6);
    if (mLog[1].size() - lb >= 6)
      for (int k = 0; k < 6; k++)
        checkOutput($sformatf("burst_grant%0d", k), 32'(mLog[1][lb+k]), 32'(burstExp[k]));

    // M=3 wrap with requesters 0 and 2
    lb = mLog[2].size();
    applyStimulus(2, 4'b0101, 32'h00C300C1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    applyStimulus(2, 4'b0000, 32'h0, 1'b0);
    checkOutput("wrap_xfer_count", 32'(xc2), 32'h4);
    checkOutput("wrap_model_ptr", 32'(mPtr[2]), 32'h0);
    checkOutput("wrap_p_data", 32'(pd2), 32'hC3);
    checkOutput("wrap_log_len", 32'(mLog[2].size() - lb), 32'h4);
    if (mLog[2].size() - lb >= 4)
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("wrap_grant%0d", k), 32'(mLog[2][lb+k]), 32'(wrapExp[k]));

    // backpressure: 0x3C held for 20 cycles while others request and data changes
    applyStimulus(0, 4'b0010, 32'h00003C00, 1'b0);
    #1;
    checkOutput("bp_grant_ready", 32'(rr0), 32'h2);
    @(posedge clk); #1;
    applyStimulus(0, 4'b1101, 32'hFFFFFFFF, 1'b0);
    for (int k = 0; k < 20; k++) begin
      checkOutput($sformatf("bp_p_valid%0d", k), 32'(pv0), 32'h1);
      checkOutput($sformatf("bp_p_data%0d", k), 32'(pd0), 32'h3C);
      checkOutput($sformatf("bp_ready%0d", k), 32'(rr0), 32'h0);
      @(posedge clk); #1;
    end
    checkOutput("bp_xfer_held", 32'(xc0), 32'h8);
    applyStimulus(0, 4'b0000, 32'h0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(0, 4'b0000, 32'h0, 1'b0);
    checkOutput("bp_after_p_valid", 32'(pv0), 32'h0);
    checkOutput("bp_after_xfer_count", 32'(xc0), 32'h9);

    // reset in the middle of HOLD
    applyStimulus(0, 4'b1000, 32'hE70000D4, 1'b0);
    @(posedge clk); #1;
    checkOutput("rst_hold_p_valid", 32'(pv0), 32'h1);
    checkOutput("rst_hold_grant_id", 32'(gid0), 32'h3);
    applyStimulus(0, 4'b1111, 32'hE70000D4, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_async_p_valid", 32'(pv0), 32'h0);
    checkOutput("rst_async_busy", 32'(bz0), 32'h0);
    checkOutput("rst_async_ready", 32'(rr0), 32'h0);
    checkOutput("rst_async_xfer_count", 32'(xc0), 32'h0);
    checkOutput("rst_async_grant_id", 32'(gid0), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    checkOutput("rst_restart_ready", 32'(rr0), 32'h1);
    @(posedge clk); #1;
    checkOutput("rst_restart_p_valid", 32'(pv0), 32'h1);
    checkOutput("rst_restart_grant_id", 32'(gid0), 32'h0);
    checkOutput("rst_restart_p_data", 32'(pd0), 32'hD4);
    applyStimulus(0, 4'b0000, 32'h0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(0, 4'b0000, 32'h0, 1'b0);
    checkOutput("rst_restart_xfer_count", 32'(xc0), 32'h1);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/p2s_rr_arbiter.md
# p2s_rr_arbiter

Round-robin arbiter that shares one parallel-to-serial serializer between M parallel requesters. Each requester offers N-bit words on a valid/ready port. The arbiter grants one requester at a time and captures the word into a holding register. It presents that word on the serializer's p_valid/p_ready/p_data port and rotates fairly, with an optional burst allowance per grant. It sits directly in front of the serializer's parallel input and reports which channel is currently being sent.

## Interface
- N, 8: word width, matches serializer p_data width.
- M, 4: number of requesters, 2..16; need not be a power of two.
- BURST, 1: max words taken from one requester per grant, ≥1.
- CW, 16: width of transfer counter.

- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  M  bit i: requester i has a word.
- req_data  in  M*N  word of requester i at bits [i*N +: N].
- req_ready  out  M  one-hot or zero; bit i: word of requester i taken this cycle.
- p_valid  out  1  word valid to serializer.
- p_data  out  N  word to serializer, from holding register.
- p_ready  in  1  serializer accepts (high only when serializer idle).
- grant_id  out  $clog2(M)  requester owning current/last word.
- busy  out  1  high in HOLD.
- xfer_count  out  CW  total words handed to serializer, wraps.

## Operation
- States: IDLE, HOLD.
- Round-robin pointer ptr, range 0..M-1.
- Winner w is the first i with req_valid[i], searching ptr, ptr+1, …, M-1, 0, …, ptr-1.
- IDLE, any req_valid:
  - req_ready[w]=1, combinationally, same cycle.
  - Next edge: data_reg<=req_data[w], grant_id<=w, burst_cnt<=1, state HOLD.
- IDLE, no req_valid: all outputs hold; req_ready=0.
- HOLD: p_valid=1, p_data=data_reg.
  - Words are never dropped or altered while p_ready=0.
- HOLD and p_ready=1 (transfer), the handshake fires and xfer_count increments. Then one of:
  - burst_cnt<BURST and req_valid[grant_id]:
    - req_ready[grant_id]=1 same cycle.
    - data_reg reloaded, burst_cnt+1, stay HOLD.
    - No bubble on p_valid.
  - Otherwise: state IDLE, ptr<=grant_id+1 with wrap to 0 at M, burst_cnt<=0.
- req_ready is never asserted for a requester with req_valid=0, and is never asserted to two requesters at once.
- req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- A requester dropping req_valid while not granted is legal and simply loses its turn in that arbitration.
- xfer_count wraps from 2^CW-1 to 0.

## Timing
- Reset values: state IDLE, ptr 0, burst_cnt 0, p_valid 0, p_data 0, grant_id 0, busy 0, req_ready 0, xfer_count 0.
- Reset mid-HOLD discards data_reg. The serializer must see p_valid fall asynchronously with rstn.
- Latency from req_valid to p_valid is 1 cycle: req_ready pulses in cycle t, and p_valid is high from the edge ending t.
- After a final transfer in HOLD at cycle t, the state is IDLE in t+1, and a new winner's p_valid rises at t+2. That leaves one bubble cycle between grants.
- Against the serializer (p_ready only when idle), each word occupies it for ≥N cycles. The arbiter bubble is hidden except when s_ready is continuously high.
- If p_ready and req_valid[grant_id] arrive in the same cycle with burst left, the reload and the handshake occur on the same edge.
- A requester asserting req_valid in the same cycle IDLE is entered (t+1) competes normally in that cycle.

## Test plan
- Single requester, M=4, BURST=1: req_valid=4'b0100 with data 0xA5, p_ready=1.
  - Expect req_ready=4'b0100 for 1 cycle, p_valid next cycle with p_data=0xA5 and grant_id=2.
  - After the transfer: IDLE, ptr=3, xfer_count=1.
- Fairness, M=4, BURST=1: all four valid continuously, p_ready=1.
  - Expect grant order 0,1,2,3,0,…, each separated by one IDLE cycle.
  - After 8 words: xfer_count=8, each requester received req_ready exactly twice.
- Burst, BURST=2: requesters 0 and 1 always valid.
  - Expect grant sequence 0,0,1,1,0,0.
  - No IDLE cycle inside a pair; req_ready[0] is asserted on the cycle of the first handshake.
- Non-power-of-two wrap, M=3: only requesters 0 and 2 valid, starting ptr=0.
  - Expect grants 0,2,0,2.
  - ptr goes 1→0 after grant 2 (wrap at 3, not 4).
- Backpressure: hold p_ready=0 for 20 cycles with 0x3C loaded.
  - Expect p_valid=1, p_data=0x3C stable, req_ready=0 throughout.
  - Raise p_ready: exactly one transfer, xfer_count+1.
- Reset mid-HOLD: pulse rstn low asynchronously while p_valid=1.
  - Expect p_valid, busy, and req_ready to go 0 immediately, and xfer_count, grant_id, ptr to go 0.
  - After release, arbitration restarts from requester 0.
